// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out serializer with lane width, bit order, backpressure and a one-word hold register
module piso_stream #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    LANE_WIDTH   = 1,
    parameter string DO_MSB_FIRST = "true"
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [LANE_WIDTH-1:0] o_data,
    output logic                  o_first,
    output logic                  o_last
);
    localparam int BEATS = DATA_WIDTH / LANE_WIDTH;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam bit MSB = DO_MSB_FIRST == "true";
    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] sh, sh_n, sh_adv, hold, hold_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  hold_valid, hold_valid_n, acc, beat, at_last;
    assign o_ready = !hold_valid && !i_s_rst;
    assign o_valid = state == SHIFT;
    assign o_first = o_valid && cnt == '0;
    assign o_last  = o_valid && cnt == LAST;
    assign o_data  = MSB ? sh[DATA_WIDTH-1 -: LANE_WIDTH] : sh[LANE_WIDTH-1:0];
    assign sh_adv  = MSB ? sh << LANE_WIDTH : sh >> LANE_WIDTH;
    assign acc     = i_valid && o_ready;
    assign beat    = o_valid && i_ready;
    assign at_last = beat && cnt == LAST;
    always_comb begin
        state_n      = state;
        sh_n         = sh;
        cnt_n        = cnt;
        hold_n       = hold;
        hold_valid_n = hold_valid;
        if (state == IDLE) begin
            if (acc) begin
                sh_n    = i_data;
                cnt_n   = '0;
                state_n = SHIFT;
            end
        end else begin
            if (beat) begin
                sh_n  = sh_adv;
                cnt_n = at_last ? '0 : cnt + 1'b1;
            end
            if (at_last) begin
                if (hold_valid) begin
                    sh_n         = hold;
                    hold_valid_n = 1'b0;
                end else if (acc) begin
                    sh_n = i_data;
                end else begin
                    state_n = IDLE;
                end
            end
            // a word arriving mid-word parks in hold unless it bypassed straight into sh
            if (acc && !at_last) begin
                hold_n       = i_data;
                hold_valid_n = 1'b1;
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            state      <= state_n;
            sh         <= sh_n;
            cnt        <= cnt_n;
            hold       <= hold_n;
            hold_valid <= hold_valid_n;
        end
    end
endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: self-checking bench over five piso_stream configurations sharing one stimulus stream
module tb_piso_stream;
    localparam int DW[5] = '{8, 8, 16, 16, 8};
    localparam int LW[5] = '{1, 1, 4, 4, 8};
    localparam int MS[5] = '{1, 0, 1, 0, 1};
    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, ready = 1'b1;
    logic [7:0]  data8 = 8'h00;
    logic [15:0] data16 = 16'h0000;
    logic        ov[5], ordy[5], ofs[5], ols[5];
    logic [7:0]  od[5];
    logic        d0o, d1o;
    logic [3:0]  d2o, d3o;
    logic [7:0]  d4o;
    int          total = 0, bad = 0;
    logic [9:0]  expq[5][256];
    int          wr[5], rd[5], inflight[5];
    bit          stall[5];
    logic [7:0]  sd[5];
    always #5 clk = ~clk;
    assign od[0] = {7'b0, d0o};
    assign od[1] = {7'b0, d1o};
    assign od[2] = {4'b0, d2o};
    assign od[3] = {4'b0, d3o};
    assign od[4] = d4o;
    piso_stream #(.DATA_WIDTH(8), .LANE_WIDTH(1), .DO_MSB_FIRST("true")) u0 (
        .i_clk(clk), .i_s_rst(rst), .i_valid(valid), .o_ready(ordy[0]), .i_data(data8),
        .o_valid(ov[0]), .i_ready(ready), .o_data(d0o), .o_first(ofs[0]), .o_last(ols[0]));
    piso_stream #(.DATA_WIDTH(8), .LANE_WIDTH(1), .DO_MSB_FIRST("false")) u1 (
        .i_clk(clk), .i_s_rst(rst), .i_valid(valid), .o_ready(ordy[1]), .i_data(data8),
        .o_valid(ov[1]), .i_ready(ready), .o_data(d1o), .o_first(ofs[1]), .o_last(ols[1]));
    piso_stream #(.DATA_WIDTH(16), .LANE_WIDTH(4), .DO_MSB_FIRST("true")) u2 (
        .i_clk(clk), .i_s_rst(rst), .i_valid(valid), .o_ready(ordy[2]), .i_data(data16),
        .o_valid(ov[2]), .i_ready(ready), .o_data(d2o), .o_first(ofs[2]), .o_last(ols[2]));
    piso_stream #(.DATA_WIDTH(16), .LANE_WIDTH(4), .DO_MSB_FIRST("false")) u3 (
        .i_clk(clk), .i_s_rst(rst), .i_valid(valid), .o_ready(ordy[3]), .i_data(data16),
        .o_valid(ov[3]), .i_ready(ready), .o_data(d3o), .o_first(ofs[3]), .o_last(ols[3]));
    piso_stream #(.DATA_WIDTH(8), .LANE_WIDTH(8), .DO_MSB_FIRST("true")) u4 (
        .i_clk(clk), .i_s_rst(rst), .i_valid(valid), .o_ready(ordy[4]), .i_data(data8),
        .o_valid(ov[4]), .i_ready(ready), .o_data(d4o), .o_first(ofs[4]), .o_last(ols[4]));

    function automatic logic [15:0] word_of(int k);
        return DW[k] == 16 ? data16 : {8'h00, data8};
    endfunction

    // lane j of word w in emission order: split into BEATS lanes, pick from top or bottom
    function automatic logic [7:0] lane_of(logic [15:0] w, int k, int j);
        int n = DW[k] / LW[k];
        int idx = MS[k] != 0 ? n - 1 - j : j;
        return 8'((32'(w) >> (idx * LW[k])) & ((32'd1 << LW[k]) - 1));
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; valid = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (ov[k] !== 1'b0 || ordy[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold k=%0d valid=%b ready=%b exp 0 0", k, ov[k], ordy[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({ov[k], ordy[k], ofs[k], ols[k], od[k]} !== 12'b0100_0000_0000) begin
                bad++;
                $display("FAIL reset_release k=%0d v/r/f/l=%b%b%b%b data=%h exp 0100 00",
                         k, ov[k], ordy[k], ofs[k], ols[k], od[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] w[5];
        do_reset();
        data8 = 8'h01; data16 = 16'h1234; valid = 1'b1;
        for (int k = 0; k < 5; k++) w[k] = word_of(k);
        @(posedge clk); #1;
        valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                int n;
                int j;
                bit ev;
                n = DW[k] / LW[k];
                j = c - 1;
                ev = j < n;
                total++;
                if (ov[k] !== ev || ofs[k] !== (ev && j == 0) || ols[k] !== (ev && j == n - 1) ||
                    (ev && od[k] !== lane_of(w[k], k, j))) begin
                    bad++;
                    $display("FAIL basic k=%0d c=%0d v/f/l=%b%b%b data=%h exp v=%b data=%h",
                             k, c, ov[k], ofs[k], ols[k], od[k], ev, lane_of(w[k], k, j));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        valid = 1'b1; data8 = 8'hF0;
        @(posedge clk); #1;
        data8 = 8'h0F;
        for (int c = 1; c <= 17; c++) begin
            bit ev;
            int j;
            logic [7:0] w;
            @(negedge clk);
            ev = c <= 16;
            j = (c - 1) % 8;
            w = c <= 8 ? 8'hF0 : 8'h0F;
            total++;
            if (ov[0] !== ev || ofs[0] !== (ev && j == 0) || ols[0] !== (ev && j == 7) ||
                (ev && od[0] !== lane_of({8'h00, w}, 0, j))) begin
                bad++;
                $display("FAIL b2b_beat c=%0d v/f/l=%b%b%b data=%h exp v=%b data=%h",
                         c, ov[0], ofs[0], ols[0], od[0], ev, lane_of({8'h00, w}, 0, j));
            end
            total++;
            if (ordy[0] !== !(c >= 2 && c <= 8)) begin
                bad++;
                $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, ordy[0], !(c >= 2 && c <= 8));
            end
            @(posedge clk); #1;
            if (c == 1) valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        valid = 1'b1; data8 = 8'hA5;
        @(posedge clk); #1;
        valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            bit ev;
            int j;
            @(negedge clk);
            ev = c <= 13;
            j = c <= 3 ? c - 1 : (c <= 9 ? 3 : c - 6);
            total++;
            if (ov[0] !== ev || ofs[0] !== (ev && j == 0) || ols[0] !== (ev && j == 7) ||
                (ev && od[0] !== lane_of(16'h00A5, 0, j))) begin
                bad++;
                $display("FAIL backpressure c=%0d v/f/l=%b%b%b data=%h exp v=%b data=%h",
                         c, ov[0], ofs[0], ols[0], od[0], ev, lane_of(16'h00A5, 0, j));
            end
            @(posedge clk); #1;
            if (c == 3) ready = 1'b0;
            if (c == 8) ready = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 1'b1; data8 = 8'hFF;
        @(posedge clk); #1;
        data8 = 8'h7E;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b1 || ordy[0] !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_during valid=%b ready=%b exp 1 0", ov[0], ordy[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (ov[0] !== 1'b0 || ordy[0] !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_after c=%0d valid=%b ready=%b exp 0 1", c, ov[0], ordy[0]);
            end
            @(posedge clk); #1;
        end
        valid = 1'b1; data8 = 8'h80;
        @(posedge clk); #1;
        valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            bit ev;
            @(negedge clk);
            ev = c <= 8;
            total++;
            if (ov[0] !== ev || (ev && od[0] !== lane_of(16'h0080, 0, c - 1))) begin
                bad++;
                $display("FAIL rstmid_fresh c=%0d valid=%b data=%h exp v=%b data=%h",
                         c, ov[0], od[0], ev, lane_of(16'h0080, 0, c - 1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beats1();
        do_reset();
        ready = 1'b0; valid = 1'b1; data8 = 8'h11;
        @(posedge clk); #1;
        data8 = 8'h22;
        @(posedge clk); #1;
        data8 = 8'h33;
        for (int c = 2; c <= 7; c++) begin
            bit ev;
            logic [7:0] w;
            @(negedge clk);
            ev = c <= 6;
            w = c <= 4 ? 8'h11 : (c == 5 ? 8'h22 : 8'h33);
            total++;
            if (ov[4] !== ev || ofs[4] !== ev || ols[4] !== ev || (ev && od[4] !== w) ||
                ordy[4] !== (c >= 5)) begin
                bad++;
                $display("FAIL beats1 c=%0d v/f/l/r=%b%b%b%b data=%h exp v=%b r=%b data=%h",
                         c, ov[4], ofs[4], ols[4], ordy[4], od[4], ev, c >= 5, w);
            end
            @(posedge clk); #1;
            if (c == 3) ready = 1'b1;
            if (c == 5) valid = 1'b0;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wr[k] = 0; rd[k] = 0; inflight[k] = 0; stall[k] = 1'b0; sd[k] = 8'h00;
        end
        for (int cyc = 0; cyc < 700; cyc++) begin
            valid = cyc < 650 && $urandom_range(0, 2) != 0;
            ready = cyc >= 650 || $urandom_range(0, 3) != 0;
            data8 = 8'($urandom);
            data16 = 16'($urandom);
            @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                total++;
                if (ordy[k] !== (inflight[k] < 2)) begin
                    bad++;
                    $display("FAIL rand_ready k=%0d cyc=%0d got=%b exp=%b", k, cyc, ordy[k], inflight[k] < 2);
                end
                if (stall[k]) begin
                    total++;
                    if (ov[k] !== 1'b1 || od[k] !== sd[k]) begin
                        bad++;
                        $display("FAIL rand_stable k=%0d cyc=%0d valid=%b data=%h exp 1 %h", k, cyc, ov[k], od[k], sd[k]);
                    end
                end
                if (ov[k] === 1'b1) begin
                    total++;
                    if (rd[k] == wr[k]) begin
                        bad++;
                        $display("FAIL rand_spurious k=%0d cyc=%0d data=%h exp no beat", k, cyc, od[k]);
                    end else if ({od[k], ofs[k], ols[k]} !== expq[k][rd[k] & 255]) begin
                        bad++;
                        $display("FAIL rand_beat k=%0d cyc=%0d data/f/l=%h/%b%b exp=%h/%b",
                                 k, cyc, od[k], ofs[k], ols[k], expq[k][rd[k] & 255][9:2], expq[k][rd[k] & 255][1:0]);
                    end
                end
                if (ov[k] === 1'b1 && ready && rd[k] != wr[k]) begin
                    if (expq[k][rd[k] & 255][0]) inflight[k]--;
                    rd[k]++;
                end
                if (valid && ordy[k] === 1'b1) begin
                    for (int j = 0; j < DW[k] / LW[k]; j++) begin
                        expq[k][wr[k] & 255] = {lane_of(word_of(k), k, j), j == 0, j == DW[k] / LW[k] - 1};
                        wr[k]++;
                    end
                    inflight[k]++;
                end
                stall[k] = ov[k] === 1'b1 && !ready;
                sd[k] = od[k];
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (wr[k] != rd[k] || ov[k] !== 1'b0) begin
                bad++;
                $display("FAIL rand_drain k=%0d pending=%0d valid=%b exp 0 0", k, wr[k] - rd[k], ov[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_beats1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
